// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//   state_e            : loader FSM states
//   LEN_BYTES          : number of bytes in the frame length field
//   PC_INITIAL_DEFAULT : default PC-domain address of image word 0
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StWrite,
    StChk,
    StDone,
    StError
  } state_e;

  localparam int unsigned LEN_BYTES          = 4;
  localparam logic [31:0] PC_INITIAL_DEFAULT = 32'hbfc00000;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four bytes, LSB first, into a little-endian 32-bit word.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : restart at byte 0 and zero the word register
//   byte_en_i     : byte_i is consumed this cycle
//   byte_i        : incoming stream byte
//   word_o        : word including the byte being consumed this cycle
//   word_done_o   : byte_i is the 4th byte; word_o is complete
module word_assembler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] merged;

  always_comb begin
    merged = word_q;
    merged[{cnt_q, 3'b000} +: 8] = byte_i;

    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d  = 2'd0;
      word_d = 32'd0;
    end else if (byte_en_i) begin
      // 2-bit counter wraps to 0 after the 4th byte, ready for the next group.
      cnt_d  = cnt_q + 2'd1;
      word_d = merged;
    end
  end

  assign word_o      = merged;
  assign word_done_o = byte_en_i && (cnt_q == 2'd3);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction RAM writer. Receives a byte stream (4-byte length N,
// then N little-endian words), writes each word at PC_INITIAL + 4*index and
// holds the CPU until the image is complete.
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte over all data bytes before DONE.
// Ports:
//   clk, resetn            : clock, asynchronous active-low reset
//   start                  : begin a load from IDLE, DONE or ERROR
//   in_valid/in_data/in_ready : byte stream handshake
//   ram_we/ram_addr/ram_wdata : instruction RAM write port
//   cpu_hold, done, error  : load status
//   words_loaded           : words written in the current or last load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] PC_INITIAL = PC_INITIAL_DEFAULT,
  parameter int unsigned MAX_WORDS  = 65536,
  parameter int unsigned COUNT_W    = 17
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               ram_we,
  output logic [31:0]        ram_addr,
  output logic [31:0]        ram_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [COUNT_W-1:0] words_loaded
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] idx_q, idx_d;
  logic [COUNT_W-1:0] len_q, len_d;
  logic [COUNT_W-1:0] words_q, words_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [COUNT_W-1:0] idx_inc;

  logic        accept;
  logic        asm_clear;
  logic        asm_en;
  logic [31:0] asm_word;
  logic        asm_done;
  logic        start_ok;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
`endif

  assign in_ready = (state_q == StLen) || (state_q == StData) || (state_q == StChk);
  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone) ||
                              (state_q == StError));
  assign asm_clear = start_ok;
  assign asm_en    = accept && ((state_q == StLen) || (state_q == StData));
  assign idx_inc   = idx_q + {{(COUNT_W-1){1'b0}}, 1'b1};

  word_assembler u_word_assembler (
    .clk_i       (clk),
    .rst_ni      (resetn),
    .clear_i     (asm_clear),
    .byte_en_i   (asm_en),
    .byte_i      (in_data),
    .word_o      (asm_word),
    .word_done_o (asm_done)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    words_d = words_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif

    if (start_ok) begin
      state_d = StLen;
      idx_d   = '0;
      words_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_d   = 8'h00;
`endif
    end else begin
      unique case (state_q)
        StLen: begin
          if (asm_done) begin
            len_d = asm_word[COUNT_W-1:0];
            if (asm_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = StChk;
`else
              state_d = StDone;
`endif
            end else if (asm_word > 32'(MAX_WORDS)) begin
              state_d = StError;
            end else begin
              state_d = StData;
            end
          end
        end
        StData: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (accept) chk_d = chk_q ^ in_data;
`endif
          if (asm_done) begin
            wdata_d = asm_word;
            addr_d  = PC_INITIAL + {{(30-COUNT_W){1'b0}}, idx_q, 2'b00};
            state_d = StWrite;
          end
        end
        StWrite: begin
          idx_d   = idx_inc;
          words_d = words_q + {{(COUNT_W-1){1'b0}}, 1'b1};
          if (idx_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = StChk;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StData;
          end
        end
        StChk: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (accept) state_d = (in_data == chk_q) ? StDone : StError;
`else
          // Unreachable without the checksum feature.
          state_d = StError;
`endif
        end
        default: ;
      endcase
    end
  end

  assign ram_we       = (state_q == StWrite);
  assign ram_addr     = addr_q;
  assign ram_wdata    = wdata_q;
  assign cpu_hold     = (state_q != StDone);
  assign done         = (state_q == StDone);
  assign error        = (state_q == StError);
  assign words_loaded = words_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      words_q <= '0;
      addr_q  <= PC_INITIAL;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) chk_q <= 8'h00;
    else         chk_q <= chk_d;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam logic [31:0] PC0 = 32'hbfc00000;
  localparam int MAXW = 65536;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, ram_we, cpu_hold, done, error;
  logic [31:0] ram_addr, ram_wdata;
  logic [16:0] words_loaded;

  imem_loader dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] wbuf[64];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (resetn && ram_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got %h<-%h expected no write", ram_addr, ram_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", ram_addr, e.a);
        check("write_data", ram_wdata, e.d);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte; a stall inserts an idle cycle first so in_valid toggles.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit r;
    int n;
    if (stall) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk); #1;
      if (r) break;
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $display("FAIL byte_timeout: got in_ready=0 for 50 cycles expected 1");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    for (int k = 0; k < 4; k++) send_byte(8'((w >> (8 * k)) & 32'hff), stall);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", {31'd0, done || error}, 32'd1);
  endtask

  // Reference: a frame of n words loads iff n <= MAXW and the checksum (if any)
  // equals the XOR of all data bytes; word i goes to PC0 + 4*i.
  task automatic run_load(input int n, input bit stall, input bit bad_chk);
    logic [7:0] x;
    bit ok;
    x = 8'h00;
    ok = (n <= MAXW);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        wr_t e;
        e.a = PC0 + 32'(i) * 32'd4;
        e.d = wbuf[i];
        exp_q.push_back(e);
        x = x ^ wbuf[i][7:0] ^ wbuf[i][15:8] ^ wbuf[i][23:16] ^ wbuf[i][31:24];
      end
    end
    pulse_start();
    send_word(32'(n), stall);
    if (ok) begin
      for (int i = 0; i < n; i++) send_word(wbuf[i], stall);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(bad_chk ? (x ^ 8'h01) : x, stall);
      if (bad_chk) ok = 1'b0;
`endif
    end
    wait_end();
    @(negedge clk);
    check("done", {31'd0, done}, {31'd0, ok});
    check("error", {31'd0, error}, {31'd0, !ok});
    check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !ok});
    check("in_ready_end", {31'd0, in_ready}, 32'd0);
    check("words_loaded", {15'd0, words_loaded}, (n <= MAXW) ? 32'(n) : 32'd0);
    check("writes_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", ram_addr, PC0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_words", {15'd0, words_loaded}, 32'd0);
    @(posedge clk); #1;

    // Two-word directed load, unstalled then with in_valid toggling.
    wbuf[0] = 32'h11223344;
    wbuf[1] = 32'haabbccdd;
    run_load(2, 1'b0, 1'b0);
    run_load(2, 1'b1, 1'b0);

    // Zero length and oversize (N = 65537), then a valid frame.
    run_load(0, 1'b0, 1'b0);
    run_load(MAXW + 1, 1'b0, 1'b0);
    wbuf[0] = 32'hdeadbeef;
    run_load(1, 1'b0, 1'b0);

    // Randomized frames.
    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      run_load(n, ($urandom_range(0, 1) == 1), 1'b0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    wbuf[0] = 32'h01020304;
    run_load(1, 1'b0, 1'b0);
    run_load(1, 1'b0, 1'b1);
`endif

    // Reset after two data bytes: no write, back to IDLE.
    pulse_start();
    send_word(32'd1, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    resetn = 1'b0;
    #1;
    check("mid_rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("mid_rst_words", {15'd0, words_loaded}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_rst_idle_ready", {31'd0, in_ready}, 32'd0);
    check("post_rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;

    // Loader must still work after the reset.
    wbuf[0] = 32'hcafef00d;
    wbuf[1] = 32'h0badc0de;
    run_load(2, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
